// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the shift/rotate unit.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic shifter: conditionally moves data by 2^K and
// tracks the last bit moved out.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned K     = 0
) (
    input  logic [2:0]       op,
    input  logic             move,
    input  logic             oor,
    input  logic             sign,
    input  logic [WIDTH-1:0] data_i,
    input  logic             cout_i,
    output logic [WIDTH-1:0] data_c,
    output logic             cout_c
);

    localparam int unsigned S = 1 << K;

    logic [WIDTH-1:0] rol_c;
    logic             sra_fill_c;

    assign rol_c      = (data_i << S) | (data_i >> (WIDTH - S));
    assign sra_fill_c = sign && (op == OP_SRA);

    // ROR arrives here already converted to a left-rotate amount.
    always_comb begin
        data_c = data_i;
        cout_c = cout_i;
        if (oor) begin
            data_c = {WIDTH{sra_fill_c}};
            cout_c = sra_fill_c;
        end else if (move) begin
            case (op)
                OP_ROL: begin
                    data_c = rol_c;
                    cout_c = rol_c[0];
                end
                OP_ROR: begin
                    data_c = rol_c;
                    cout_c = rol_c[WIDTH-1];
                end
                OP_SHL: begin
                    data_c = data_i << S;
                    cout_c = data_i[WIDTH-S];
                end
                OP_SHR: begin
                    data_c = data_i >> S;
                    cout_c = data_i[S-1];
                end
                OP_SRA: begin
                    data_c = WIDTH'($signed(data_i) >>> S);
                    cout_c = data_i[S-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Pipelined logarithmic shift/rotate unit: one stage per amount bit, with a
// single global advance so the whole pipe moves or stalls together.
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             cout
);

    logic             advance;
    logic             oor_in;
    logic [LOG2W-1:0] amt_in;

    // Pipeline registers; the last stage keeps only what drives the outputs.
    logic [LOG2W-1:0] v_q;
    logic [LOG2W-1:0] cout_q;
    logic [WIDTH-1:0] data_q [LOG2W];
    logic [2:0]       op_q   [LOG2W-1];
    logic [LOG2W-1:0] amt_q  [LOG2W-1];
    logic [LOG2W-2:0] oor_q;
    logic [LOG2W-2:0] sign_q;

    // Per-stage inputs and outputs.
    logic [2:0]       st_op   [LOG2W];
    logic [LOG2W-1:0] st_amt  [LOG2W];
    logic [LOG2W-1:0] st_oor;
    logic [LOG2W-1:0] st_sign;
    logic [WIDTH-1:0] st_data [LOG2W];
    logic [LOG2W-1:0] st_cout;
    logic [WIDTH-1:0] data_c  [LOG2W];
    logic [LOG2W-1:0] cout_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ROR by M becomes ROL by -M mod WIDTH; shifts flag any high amount bits.
    assign amt_in = (op == OP_ROR) ? LOG2W'(~B[LOG2W-1:0] + 1'b1) : B[LOG2W-1:0];
    assign oor_in = is_shift(op) && (|B[WIDTH-1:LOG2W]);

    always_comb begin
        st_op[0]   = op;
        st_amt[0]  = amt_in;
        st_oor[0]  = oor_in;
        st_sign[0] = A[WIDTH-1];
        st_data[0] = A;
        st_cout[0] = 1'b0;
        for (int k = 1; k < LOG2W; k++) begin
            st_op[k]   = op_q[k-1];
            st_amt[k]  = amt_q[k-1];
            st_oor[k]  = oor_q[k-1];
            st_sign[k] = sign_q[k-1];
            st_data[k] = data_q[k-1];
            st_cout[k] = cout_q[k-1];
        end
    end

    // Amount is consumed LSB-first: each register passes it on shifted right.
    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .op     (st_op[k]),
            .move   (st_amt[k][0]),
            .oor    (st_oor[k]),
            .sign   (st_sign[k]),
            .data_i (st_data[k]),
            .cout_i (st_cout[k]),
            .data_c (data_c[k]),
            .cout_c (cout_c[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            cout_q <= '0;
            oor_q  <= '0;
            sign_q <= '0;
            for (int k = 0; k < LOG2W; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                op_q[k]  <= '0;
                amt_q[k] <= '0;
            end
        end else if (advance) begin
            v_q    <= {v_q[LOG2W-2:0], in_valid};
            cout_q <= cout_c;
            for (int k = 0; k < LOG2W; k++) begin
                data_q[k] <= data_c[k];
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                op_q[k]   <= st_op[k];
                amt_q[k]  <= st_amt[k] >> 1;
                oor_q[k]  <= st_oor[k];
                sign_q[k] <= st_sign[k];
            end
        end
    end

    assign out_valid = v_q[LOG2W-1];
    assign R         = data_q[LOG2W-1];
    assign cout      = cout_q[LOG2W-1];
    assign zero      = ~|R;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit at WIDTH=32: single ops, stall, reset.
module tb_shift_rotate_unit;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    shift_rotate_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .zero      (zero),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic c);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        A         = a;
        B         = b;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        check_eq({tag, "_lat"}, 32'(lat), 32'd5);
        check_eq({tag, "_r"}, R, r);
        check_eq({tag, "_cout"}, 32'(cout), 32'(c));
        check_eq({tag, "_zero"}, 32'(zero), 32'(r == 32'd0));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_r"}, R, 32'd0);
        check_eq({tag, "_zero"}, 32'(zero), 32'd1);
        check_eq({tag, "_cout"}, 32'(cout), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] stim [8];
        logic [31:0] held;
        int          snd, rcv, cyc, stalls, extra;
        logic        stalled_prev;

        #3;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("rol1",    OP_ROL, 32'h8000_0001, 32'd1,   32'h0000_0003, 1'b1);
        run_one("ror36",   OP_ROR, 32'h0000_00F1, 32'd36,  32'h1000_000F, 1'b0);
        run_one("sra40",   OP_SRA, 32'h8000_0000, 32'd40,  32'hFFFF_FFFF, 1'b1);
        run_one("shl32",   OP_SHL, 32'hFFFF_FFFF, 32'd32,  32'h0000_0000, 1'b0);
        run_one("shr5",    OP_SHR, 32'h0000_0010, 32'd5,   32'h0000_0000, 1'b1);
        run_one("rol0",    OP_ROL, 32'h1234_5678, 32'd0,   32'h1234_5678, 1'b0);
        run_one("shl4",    OP_SHL, 32'h1234_5678, 32'd4,   32'h2345_6780, 1'b1);
        run_one("shr8",    OP_SHR, 32'h1234_5678, 32'd8,   32'h0012_3456, 1'b0);
        run_one("sra4",    OP_SRA, 32'hF000_0000, 32'd4,   32'hFF00_0000, 1'b0);
        run_one("sra31",   OP_SRA, 32'h8000_0000, 32'd31,  32'hFFFF_FFFF, 1'b0);
        run_one("ror1",    OP_ROR, 32'h0000_0001, 32'd1,   32'h8000_0000, 1'b1);
        run_one("rol33",   OP_ROL, 32'h8000_0000, 32'd33,  32'h0000_0001, 1'b1);
        run_one("pass5",   3'b101, 32'hDEAD_BEEF, 32'd3,   32'hDEAD_BEEF, 1'b0);
        run_one("pass7",   3'b111, 32'h0000_0000, 32'd9,   32'h0000_0000, 1'b0);
        run_one("shl31",   OP_SHL, 32'h0000_0001, 32'd31,  32'h8000_0000, 1'b0);
        run_one("shr31",   OP_SHR, 32'h8000_0000, 32'd31,  32'h0000_0001, 1'b0);
        run_one("shrbig",  OP_SHR, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_one("sra100",  OP_SRA, 32'h7FFF_FFFF, 32'd100, 32'h0000_0000, 1'b0);
        run_one("ror32",   OP_ROR, 32'h1234_5678, 32'd32,  32'h1234_5678, 1'b0);
        run_one("shr0",    OP_SHR, 32'h0000_0005, 32'd0,   32'h0000_0005, 1'b0);
        run_one("ror8",    OP_ROR, 32'h1234_5678, 32'd8,   32'h7812_3456, 1'b0);
        run_one("rol4",    OP_ROL, 32'h1234_5678, 32'd4,   32'h2345_6781, 1'b1);

        // Back-to-back stream with the consumer stalled for cycles 6..8.
        for (int i = 0; i < 8; i++) stim[i] = 32'(i * 3 + 1);
        snd = 0; rcv = 0; cyc = 0; stalls = 0; stalled_prev = 1'b0; held = '0;
        while (rcv < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (snd < 8) begin
                in_valid = 1'b1;
                op       = OP_ROR;
                A        = stim[snd];
                B        = 32'd1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                if (stalled_prev) check_eq("stall_hold", R, held);
                held         = R;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready && rcv < 8) begin
                check_eq("stream_r", R, {stim[rcv][0], stim[rcv][31:1]});
                check_eq("stream_cout", 32'(cout), 32'(stim[rcv][0]));
                rcv++;
            end
            if (in_valid && in_ready) snd++;
            cyc++;
        end
        check_eq("stream_count", 32'(rcv), 32'd8);
        check_eq("stall_cycles", 32'(stalls), 32'd3);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_eq("stream_no_dup", 32'(extra), 32'd0);

        // Reset with three operands in flight, first one already at the output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = OP_SHL;
            A        = 32'h0000_0001;
            B        = 32'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        check_eq("pre_rst_r", R, 32'h0000_0002);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_eq("post_rst_stale", 32'(extra), 32'd0);
        run_one("post_rst", OP_ROL, 32'hA000_0005, 32'd2, 32'h8000_0016, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two, 8..64.
REQ-002 Parameter LOG2W, default $clog2(WIDTH), shift-stage count and pipeline depth.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/op presented this cycle.
REQ-006 in_ready  output  1  unit accepts operand when in_valid && in_ready.
REQ-007 op  input  3  operation select, encoding per REQ-012.
REQ-008 A  input  WIDTH  data operand.
REQ-009 B  input  WIDTH  shift/rotate amount; full width is examined.
REQ-010 out_valid  output  1  result held on R/flags.
REQ-011 out_ready  input  1  consumer accepts result when out_valid && out_ready; R  output  WIDTH  result; zero  output  1  R==0; cout  output  1  last bit shifted/rotated out.

Function
REQ-012 op: 000 ROL, 001 ROR, 010 SHL, 011 SHR (logical), 100 SRA (arithmetic); 101-111 SHALL pass A unchanged with cout=0.
REQ-013 Rotates use amount M = B mod WIDTH (low LOG2W bits); M=0 returns A, cout=0.
REQ-014 Shifts use full B: B >= WIDTH gives R=0 (SHL/SHR) or R = WIDTH copies of A[WIDTH-1] (SRA); B=0 returns A, cout=0.
REQ-015 cout for nonzero amount: SHL -> A[WIDTH-M]; SHR/SRA -> A[M-1]; ROL -> R[0]; ROR -> R[WIDTH-1]; shift with B >= WIDTH -> 0 (SHL/SHR), A[WIDTH-1] (SRA).
REQ-016 ROR by M SHALL be implemented as ROL by (WIDTH-M) mod WIDTH; SHR/SRA as right shifts, no bit-reversal trick required.
REQ-017 Datapath is a logarithmic shifter: stage k (k=0..LOG2W-1) conditionally moves by 2^k, followed by a pipeline register.
REQ-018 Latency: accepted operand appears on R exactly LOG2W cycles later when no stall (5 cycles at WIDTH=32).
REQ-019 Each pipeline register carries valid, op, data, out-of-range flag, sign bit, running cout; zero computed combinationally from final stage register.
REQ-020 Global advance = !out_valid || out_ready; all stages shift together when advance=1, all hold when 0.
REQ-021 in_ready SHALL equal advance; bubbles are not compressed.
REQ-022 Throughput: one result per cycle while out_ready=1 and in_valid=1.
REQ-023 While out_valid && !out_ready, R, zero, cout, out_valid SHALL remain stable.
REQ-024 in_valid=0 on an advance cycle SHALL insert a bubble (valid=0) into stage 0.
REQ-025 Unused stage data (valid=0) is don't-care but SHALL NOT affect out_valid.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, R=0, zero=1, cout=0.
REQ-027 Reset mid-operation discards all in-flight operands; no partial result emitted.
REQ-028 First operand may be accepted on the first rising edge with rst_n high; in_ready=1 during and after reset.

Structure
REQ-029 Shared package shift_pkg SHALL hold op encodings (OP_ROL..OP_SRA) and default WIDTH constant.
REQ-030 One sub-module shift_stage (parameters WIDTH, K): combinational 2^k move for all ops plus cout update, instantiated LOG2W times via generate.
REQ-031 No multipliers, dividers or modulo operators in RTL; mod WIDTH is bit-slicing.

Verification
REQ-032 ROL, A=0x8000_0001, B=1 -> R=0x0000_0003, cout=1, out_valid 5 cycles after accept.
REQ-033 ROR, A=0x0000_00F1, B=36 (mod 4) -> R=0x1000_000F, cout=0; SRA, A=0x8000_0000, B=40 -> R=0xFFFF_FFFF, cout=1.
REQ-034 SHL, A=0xFFFF_FFFF, B=32 -> R=0, zero=1, cout=0; SHR, A=0x0000_0010, B=5 -> R=0, zero=1, cout=1.
REQ-035 Back-to-back 8 operands with out_ready low for cycles 6-8 -> R held stable, in_ready=0 while stalled, all 8 results in order, none lost/duplicated.
REQ-036 rst_n pulsed low with 3 operands in flight -> out_valid=0 immediately, no stale result after release; next operand returns correct result at LOG2W latency.
REQ-037 Random regression at WIDTH=8,32,64 against reference model for all ops, B ranging 0..2*WIDTH, random in_valid/out_ready.
